pipe_scoreboard: RTL
====================

Name: pipe_scoreboard

Overview:
- In-order issue controller between pipe_idu and the execute stage.
- Tracks outstanding register writes in per-register counters and an in-flight uop counter.
- Stalls issue on RAW hazards against the regfile and on resource saturation; gates the id_valid/ex_ready handshake.
- Clears all tracking on pipeline flush.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero, never tracked)
- AW, 5, register index width (log2 NREG)
- CNT_W, 2, width of each per-register pending-write counter; saturates at 2^CNT_W-1
- MAX_INFLIGHT, 4, maximum issued-but-not-retired uops
- IF_W, 3, width of inflight_o (must hold MAX_INFLIGHT)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  squash all in-flight uops
- id_valid_i  in  1  decoded uop valid from IDU
- id_ready_o  out  1  scoreboard/EX accepts uop
- ex_valid_o  out  1  uop issued to EX
- ex_ready_i  in  1  EX can accept
- rs1_i  in  AW  source 1 index
- rs1_ren_i  in  1  source 1 used
- rs2_i  in  AW  source 2 index
- rs2_ren_i  in  1  source 2 used
- rd_i  in  AW  destination index
- rd_wen_i  in  1  uop writes rd
- retire_valid_i  in  1  one uop retires this cycle
- retire_wen_i  in  1  retiring uop wrote a register
- retire_rd_i  in  AW  retiring destination
- pending_o  out  NREG  bit i = register i has outstanding write
- inflight_o  out  IF_W  current in-flight count
- err_o  out  1  sticky underflow error

Behaviour:
- State: cnt[1..NREG-1] (CNT_W each), inflight (IF_W), err. Reset: all cnt=0, inflight=0, err=0.
- While rst_i=1, id_ready_o=0 and ex_valid_o=0. pending_o and inflight_o reflect registered state (all 0 after reset).
- RAW hazard when either source is used, nonzero, and has pending writes:
  - (rs1_ren_i && rs1_i!=0 && cnt[rs1_i]!=0), or
  - (rs2_ren_i && rs2_i!=0 && cnt[rs2_i]!=0).
- WAW saturation: rd_wen_i && rd_i!=0 && cnt[rd_i]==2^CNT_W-1.
- Full: inflight==MAX_INFLIGHT.
- stall = RAW | WAW saturation | Full. All terms use registered state only; no same-cycle bypass from retire, since the regfile write lands at the edge.
- Handshake outputs (combinational):
  - ex_valid_o = id_valid_i & ~stall & ~flush_i & ~rst_i
  - id_ready_o = ex_ready_i & ~stall & ~flush_i & ~rst_i
  - fire = id_valid_i & id_ready_o
  - ex_valid_o may assert with ex_ready_i=0; no state change occurs unless fire.
- Issue latency: zero cycles (pass-through). Counters update at the next edge.
- On fire: inflight+1. If rd_wen_i && rd_i!=0, cnt[rd_i]+1.
- On retire_valid_i: inflight-1. If retire_wen_i && retire_rd_i!=0, cnt[retire_rd_i]-1.
- Fire and retire in the same cycle:
  - inflight unchanged.
  - Same rd on both sides: cnt unchanged.
  - Different rd: each counter updates independently.
- Underflow (retire with inflight==0, or retire decrementing cnt==0):
  - The offending decrement is ignored and the counter holds at 0.
  - err_o sets and stays set until rst_i.
- flush_i=1:
  - fire is suppressed; retire_valid_i is ignored that cycle.
  - At the next edge, all cnt=0 and inflight=0. err unchanged.
  - Retires arriving after a flush for squashed uops are an integration error and trigger the underflow rule.
- rd_i=0 or retire_rd_i=0 never touches counters; pending_o[0] is always 0.
- Reset during operation: all state clears at the edge regardless of flush, fire or retire.

Test Plan:
- Reset, then id_valid_i=1, rd=5, rd_wen=1, ex_ready_i=1 -> ex_valid_o=1 same cycle; next cycle pending_o[5]=1, inflight_o=1.
- With cnt[5]=1, issue rs1=5, rs1_ren=1 -> id_ready_o=0, ex_valid_o=0. Retire rd=5 -> next cycle the same uop fires.
- Issue 4 uops (rd=1,2,3,4) with no retire -> the 5th is stalled, inflight_o=4. One retire -> 5th fires the following cycle, inflight_o stays 4.
- Issue rd=7 three times (CNT_W=2) -> the 4th write to rd=7 stalls on WAW saturation. Simultaneous fire rd=7 and retire rd=7 from cnt=2 -> cnt stays 2.
- Assert flush_i with inflight_o=3, pending_o=0x0000_0016 and a coincident retire -> next cycle inflight_o=0, pending_o=0, err_o=0.
- retire_valid_i with inflight_o=0 -> inflight_o stays 0, err_o=1 and stays 1 until rst_i. rd=0 issue -> pending_o unchanged.

Source files
------------

// File: rtl/pipe_scoreboard_if.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard_if
//
// Bundles every signal between the in-order issue scoreboard and its
// neighbours: the decode unit (IDU), the execute stage, the retire path
// and flush control.
//
// Signal names keep the scoreboard's point of view (_i = into the
// scoreboard, _o = out of it) so that both sides of a connection use the
// same name.
//
//   flush_i         squash everything in flight
//   id_valid_i      decoded uop valid
//   id_ready_o      scoreboard / EX accepts the uop
//   ex_valid_o      uop issued to EX
//   ex_ready_i      EX can accept
//   rs1_i/rs1_ren_i source 1 index / used
//   rs2_i/rs2_ren_i source 2 index / used
//   rd_i/rd_wen_i   destination index / written
//   retire_valid_i  one uop retires this cycle
//   retire_wen_i    retiring uop wrote a register
//   retire_rd_i     retiring destination index
//   pending_o       bit i = register i has an outstanding write
//   inflight_o      issued-but-not-retired count
//   err_o           sticky underflow error
//
// Modports:
//   slave  - the scoreboard itself
//   master - the surrounding pipeline (IDU / EX / retire / flush control)
// ---------------------------------------------------------------------------
interface pipe_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int IF_W = 3
);
    logic            flush_i;
    logic            id_valid_i;
    logic            id_ready_o;
    logic            ex_valid_o;
    logic            ex_ready_i;
    logic [AW-1:0]   rs1_i;
    logic            rs1_ren_i;
    logic [AW-1:0]   rs2_i;
    logic            rs2_ren_i;
    logic [AW-1:0]   rd_i;
    logic            rd_wen_i;
    logic            retire_valid_i;
    logic            retire_wen_i;
    logic [AW-1:0]   retire_rd_i;
    logic [NREG-1:0] pending_o;
    logic [IF_W-1:0] inflight_o;
    logic            err_o;

    modport slave (
        input  flush_i,
        input  id_valid_i,
        output id_ready_o,
        output ex_valid_o,
        input  ex_ready_i,
        input  rs1_i,
        input  rs1_ren_i,
        input  rs2_i,
        input  rs2_ren_i,
        input  rd_i,
        input  rd_wen_i,
        input  retire_valid_i,
        input  retire_wen_i,
        input  retire_rd_i,
        output pending_o,
        output inflight_o,
        output err_o
    );

    modport master (
        output flush_i,
        output id_valid_i,
        input  id_ready_o,
        input  ex_valid_o,
        output ex_ready_i,
        output rs1_i,
        output rs1_ren_i,
        output rs2_i,
        output rs2_ren_i,
        output rd_i,
        output rd_wen_i,
        output retire_valid_i,
        output retire_wen_i,
        output retire_rd_i,
        input  pending_o,
        input  inflight_o,
        input  err_o
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
//
// In-order issue controller sitting between the decode unit and the execute
// stage. It keeps a small saturating counter of outstanding writes per
// architectural register plus a count of issued-but-not-retired uops, and
// holds back issue when:
//   - a used, nonzero source register still has a write outstanding (RAW),
//   - the destination counter is already at its maximum (WAW saturation),
//   - the in-flight window is full.
// Issue is a zero-latency pass-through: ex_valid_o / id_ready_o are pure
// combinational functions of the inputs and registered state; the counters
// move at the following clock edge.
//
// Ports:
//   clk_i  clock
//   rst_i  synchronous reset, active-high; clears all tracking and err_o,
//          and forces id_ready_o / ex_valid_o low while asserted
//   sb     pipe_scoreboard_if.slave - handshake, register indices,
//          retire path, flush and status outputs
// ---------------------------------------------------------------------------
module pipe_scoreboard #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int IF_W         = 3
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IF_W-1:0]  IF_MAX  = IF_W'(MAX_INFLIGHT);
    localparam logic [IF_W-1:0]  IF_ONE  = IF_W'(1);

    // Per-register status flattened into vectors so that the hazard checks
    // can index by register number. Bit 0 (x0) is tied low: x0 is never
    // tracked, so it can never raise a hazard or an underflow.
    logic [NREG-1:0] pend_vec;
    logic [NREG-1:0] sat_vec;
    logic [NREG-1:0] cnt_uflow;

    logic [IF_W-1:0] inflight_reg;
    logic [IF_W-1:0] inflight_next;
    logic            err_reg;
    logic            err_next;

    logic raw_hz;
    logic waw_sat;
    logic full;
    logic stall;
    logic id_ready;
    logic ex_valid;
    logic fire;
    logic retire_eff;
    logic if_uflow;
    logic if_dec_ok;

    assign pend_vec[0]  = 1'b0;
    assign sat_vec[0]   = 1'b0;
    assign cnt_uflow[0] = 1'b0;

    // -----------------------------------------------------------------------
    // Issue gating. Only registered state is consulted: a retire in this
    // cycle does not release a hazard until the regfile write has landed at
    // the next edge.
    // -----------------------------------------------------------------------
    always_comb begin
        raw_hz  = (sb.rs1_ren_i && (sb.rs1_i != '0) && pend_vec[sb.rs1_i]) ||
                  (sb.rs2_ren_i && (sb.rs2_i != '0) && pend_vec[sb.rs2_i]);
        waw_sat = sb.rd_wen_i && (sb.rd_i != '0) && sat_vec[sb.rd_i];
        full    = (inflight_reg == IF_MAX);
        stall   = raw_hz || waw_sat || full;
    end

    assign ex_valid = sb.id_valid_i & ~stall & ~sb.flush_i & ~rst_i;
    assign id_ready = sb.ex_ready_i & ~stall & ~sb.flush_i & ~rst_i;
    assign fire     = sb.id_valid_i & id_ready;

    // A flush cycle ignores the retire port entirely.
    assign retire_eff = sb.retire_valid_i & ~sb.flush_i;

    // -----------------------------------------------------------------------
    // Per-register pending-write counters (x1 .. x{NREG-1}).
    // An increment and a valid decrement on the same register cancel out.
    // A decrement of a zero counter is dropped (and flagged as an error);
    // a coincident increment on that register still applies.
    // The WAW stall guarantees an increment never sees a saturated counter.
    // -----------------------------------------------------------------------
    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
        localparam logic [AW-1:0] IDX = AW'(gi);

        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             inc;
        logic             dec;
        logic             dec_ok;

        always_comb begin
            inc      = fire && sb.rd_wen_i && (sb.rd_i == IDX);
            dec      = retire_eff && sb.retire_wen_i && (sb.retire_rd_i == IDX);
            dec_ok   = dec && (cnt_reg != '0);
            cnt_next = cnt_reg;
            case ({inc, dec_ok})
                2'b10:   cnt_next = cnt_reg + CNT_W'(1);
                2'b01:   cnt_next = cnt_reg - CNT_W'(1);
                default: cnt_next = cnt_reg;
            endcase
        end

        assign cnt_uflow[gi] = dec && (cnt_reg == '0);
        assign pend_vec[gi]  = (cnt_reg != '0);
        assign sat_vec[gi]   = (cnt_reg == CNT_MAX);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_reg <= '0;
            end else if (sb.flush_i) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // In-flight uop counter. Same cancel / drop rules as the register
    // counters. The full stall keeps a fire from ever exceeding
    // MAX_INFLIGHT.
    // -----------------------------------------------------------------------
    always_comb begin
        if_uflow      = retire_eff && (inflight_reg == '0);
        if_dec_ok     = retire_eff && !if_uflow;
        inflight_next = inflight_reg;
        case ({fire, if_dec_ok})
            2'b10:   inflight_next = inflight_reg + IF_ONE;
            2'b01:   inflight_next = inflight_reg - IF_ONE;
            default: inflight_next = inflight_reg;
        endcase
    end

    // Sticky error: any dropped decrement (window or register) sets it and
    // only reset clears it; flush leaves it alone.
    assign err_next = err_reg | if_uflow | (|cnt_uflow);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (sb.flush_i) begin
                inflight_reg <= '0;
            end else begin
                inflight_reg <= inflight_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sb.id_ready_o = id_ready;
    assign sb.ex_valid_o = ex_valid;
    assign sb.pending_o  = pend_vec;
    assign sb.inflight_o = inflight_reg;
    assign sb.err_o      = err_reg;

endmodule
